// File: rtl/cbus_arbiter.sv
// Shares one cbus port among NUM_REQ cache requesters; grant held for a whole burst.
// Define CBUS_ARB_FIXED_PRIO_EN for fixed-priority selection (default: round-robin).
package cbus_pkg;
    // len is beats-1: 8'd0 = MLEN1, 8'd255 = MLEN256
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_REQ-1:0]    ireqs,
    output cbus_resp_t [NUM_REQ-1:0]    iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic                        busy,
    output logic       [IDX_W-1:0]      grant_idx
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_cand;
    logic             w_any;
    logic             w_done;

    assign w_done    = oresp.ready && oresp.last;
    assign grant_idx = r_grant;

`ifdef CBUS_ARB_FIXED_PRIO_EN
    // Scan from the top so the lowest valid index is the last to overwrite.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = IDX_W'(k);
            if (ireqs[w_cand].valid) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end
`else
    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] w_rr_next;
    int               w_scan;

    always_comb begin
        w_any    = 1'b0;
        w_winner = r_rr;
        w_cand   = '0;
        w_scan   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_rr) + k;
            if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
            w_cand = IDX_W'(w_scan);
            if (!w_any && ireqs[w_cand].valid) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Explicit wrap so non-power-of-2 NUM_REQ never lands on an unused index.
    assign w_rr_next = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk) begin
        if (reset)                          r_rr <= '0;
        else if (r_state == BUSY && w_done) r_rr <= w_rr_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset)                         r_grant <= '0;
        else if (r_state == IDLE && w_any) r_grant <= w_winner;
    end

    // Leaving BUSY always lands in IDLE, so a new selection never overlaps the final beat.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any)  w_next = BUSY;
            BUSY:    if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        oreq   = '0;
        iresps = '0;
        busy   = (r_state == BUSY);
        if (r_state == BUSY) begin
            oreq            = ireqs[r_grant];
            iresps[r_grant] = oresp;
        end
    end

`ifdef ASSERT
    a_owner_holds_valid: assert property (@(posedge clk) disable iff (reset)
        (r_state == BUSY) |-> ireqs[r_grant].valid);
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: owner-level model checked every cycle plus literal grant/beat expectations.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    cbus_req_t  [N-1:0]   ireqs;
    cbus_resp_t [N-1:0]   iresps;
    cbus_req_t            oreq;
    cbus_resp_t           oresp;
    logic                 busy;
    logic [0:0]           grant_idx;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: who owns the bus (-1 = nobody), rotating start point, last granted index
    int m_owner = -1;
    int m_rr    = 0;
    int m_gidx  = 0;
    int glog[$];
    int rdy_cnt[N];
    int nz0_cnt = 0;

    cbus_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
        .oreq(oreq), .oresp(oresp), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic int pick(input int rr, input cbus_req_t [N-1:0] rq);
        int j;
        for (int k = 0; k < N; k++) begin
`ifdef CBUS_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (rr + k) % N;
`endif
            if (rq[j].valid) return j;
        end
        return -1;
    endfunction

    function automatic cbus_req_t mk(input bit wr, input logic [63:0] a, input logic [7:0] len,
                                     input logic [7:0] strb, input logic [63:0] d);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 3'd3;
        r.addr     = a;
        r.len      = len;
        r.strobe   = strb;
        r.data     = d;
        return r;
    endfunction

    always @(posedge clk) begin
        automatic int w;
        if (reset) begin
            m_owner <= -1;
            m_rr    <= 0;
            m_gidx  <= 0;
        end else if (m_owner < 0) begin
            w = pick(m_rr, ireqs);
            if (w >= 0) begin
                m_owner <= w;
                m_gidx  <= w;
                glog.push_back(w);
            end
        end else if (oresp.ready && oresp.last) begin
            m_owner <= -1;
            m_rr    <= (m_owner + 1) % N;
        end
    end

    always @(negedge clk) begin
        automatic cbus_req_t        e_req;
        automatic cbus_resp_t [N-1:0] e_rsp;
        automatic logic [0:0]       oi;
        if (cmp_en) begin
            e_req = '0;
            e_rsp = '0;
            oi    = 1'(m_owner);
            if (m_owner >= 0) begin
                e_req     = ireqs[oi];
                e_rsp[oi] = oresp;
            end
            chk("busy", 192'(busy), 192'(m_owner >= 0));
            chk("grant_idx", 192'(grant_idx), 192'(m_gidx));
            chk("oreq", 192'(oreq), 192'(e_req));
            chk("iresps0", 192'(iresps[0]), 192'(e_rsp[0]));
            chk("iresps1", 192'(iresps[1]), 192'(e_rsp[1]));
            if (iresps[0].ready) rdy_cnt[0]++;
            if (iresps[1].ready) rdy_cnt[1]++;
            if (iresps[0] != '0) nz0_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        tick();
        tick();
        reset = 1'b0;
        glog.delete();
    endtask

    task automatic wait_busy(input string nm);
        int t;
        t = 0;
        while (!busy && t < 50) begin
            tick();
            t++;
        end
        if (!busy) begin
            checks++;
            errors++;
            $display("FAIL %s got=no_grant exp=busy", nm);
        end
    endtask

    // Memory side: stream `beats` ready beats; requester `drop` releases valid once it sees last.
    task automatic run_burst(input int beats, input int drop);
        wait_busy("burst_wait");
        for (int i = 0; i < beats; i++) begin
            oresp.ready = 1'b1;
            oresp.last  = (i == beats - 1);
            oresp.data  = 64'(i) ^ 64'hA5A5_0000_0000_5A5A;
            tick();
        end
        oresp = '0;
        if (drop >= 0) ireqs[1'(drop)].valid = 1'b0;
    endtask

    int exp_seq[4];
    int base_rdy, base_nz;
    cbus_req_t req4;

    initial begin
        ireqs  = '0;
        oresp  = '0;
        reset  = 1'b1;
        tick();
        cmp_en = 1'b1;
        chk("reset_busy", 192'(busy), 192'(0));
        chk("reset_grant", 192'(grant_idx), 192'(0));
        chk("reset_oreq", 192'(oreq), 192'(0));
        tick();
        reset = 1'b0;

        // 1: lone 256-beat read from port 1
        do_reset();
        base_rdy = rdy_cnt[1];
        base_nz  = nz0_cnt;
        ireqs[1] = mk(1'b0, 64'h1000, 8'd255, 8'hff, 64'h0);
        @(negedge clk);
        chk("t1_valid_t0", 192'(oreq.valid), 192'(0));
        tick();
        chk("t1_valid_t1", 192'(oreq.valid), 192'(1));
        chk("t1_grant", 192'(grant_idx), 192'(1));
        run_burst(256, 1);
        chk("t1_busy_fall", 192'(busy), 192'(0));
        chk("t1_beats", 192'(rdy_cnt[1] - base_rdy), 192'(256));
        chk("t1_port0_quiet", 192'(nz0_cnt - base_nz), 192'(0));

        // 2: both valid from reset
        do_reset();
        ireqs[0] = mk(1'b0, 64'h2000, 8'd3, 8'hff, 64'h0);
        ireqs[1] = mk(1'b0, 64'h3000, 8'd3, 8'hff, 64'h0);
        run_burst(4, 0);
        chk("t2_bubble_valid", 192'(oreq.valid), 192'(0));
        chk("t2_bubble_busy", 192'(busy), 192'(0));
        tick();
        chk("t2_second_valid", 192'(oreq.valid), 192'(1));
        chk("t2_second_grant", 192'(grant_idx), 192'(1));
        run_burst(4, 1);
        chk("t2_nlog", 192'(glog.size()), 192'(2));
        chk("t2_first", 192'(glog.size() > 0 ? glog[0] : -1), 192'(0));
        chk("t2_second", 192'(glog.size() > 1 ? glog[1] : -1), 192'(1));

        // 3: both continuously valid over four bursts
        do_reset();
        ireqs[0] = mk(1'b0, 64'h4000, 8'd1, 8'hff, 64'h0);
        ireqs[1] = mk(1'b1, 64'h5000, 8'd1, 8'h0f, 64'h1234);
        for (int b = 0; b < 4; b++) run_burst(2, -1);
        ireqs = '0;
`ifdef CBUS_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        chk("t3_nlog", 192'(glog.size()), 192'(4));
        for (int i = 0; i < 4; i++)
            chk("t3_grant_seq", 192'(glog.size() > i ? glog[i] : -1), 192'(exp_seq[i]));
        tick();

        // 4: uncached single-beat write from port 1
        do_reset();
        req4 = mk(1'b1, 64'h4060_0004, 8'd0, 8'h0f, 64'hDEAD_BEEF_0BAD_F00D);
        req4.size = 3'd2;
        ireqs[1] = req4;
        tick();
        chk("t4_oreq_fields", 192'(oreq), 192'(req4));
        base_rdy = rdy_cnt[1];
        run_burst(1, 1);
        tick();
        tick();
        chk("t4_ready_cycles", 192'(rdy_cnt[1] - base_rdy), 192'(1));
        chk("t4_idle", 192'(busy), 192'(0));

        // 5: reset at beat 100 of a 256-beat burst
        do_reset();
        ireqs[1] = mk(1'b0, 64'h6000, 8'd255, 8'hff, 64'h0);
        wait_busy("t5_wait");
        for (int i = 0; i <= 100; i++) begin
            oresp.ready = 1'b1;
            oresp.last  = 1'b0;
            oresp.data  = 64'(i);
            if (i == 100) reset = 1'b1;
            tick();
        end
        chk("t5_busy", 192'(busy), 192'(0));
        chk("t5_valid", 192'(oreq.valid), 192'(0));
        chk("t5_grant", 192'(grant_idx), 192'(0));
        chk("t5_resp1", 192'(iresps[1]), 192'(0));
        reset = 1'b0;
        oresp = '0;
        ireqs = '0;
        glog.delete();
        ireqs[0] = mk(1'b0, 64'h7000, 8'd2, 8'hff, 64'h0);
        run_burst(3, 0);
        chk("t5_regrant", 192'(glog.size() > 0 ? glog[0] : -1), 192'(0));

        // 6: owner drops valid mid-burst while port 0 waits
        do_reset();
        ireqs[1] = mk(1'b0, 64'h8000, 8'd7, 8'hff, 64'h0);
        wait_busy("t6_wait");
        for (int i = 0; i < 8; i++) begin
            oresp.ready = 1'b1;
            oresp.last  = (i == 7);
            oresp.data  = 64'(i);
            if (i == 3) begin
                ireqs[1].valid = 1'b0;
                ireqs[0] = mk(1'b0, 64'h9000, 8'd1, 8'hff, 64'h0);
            end
            if (i == 5) begin
                chk("t6_busy_hold", 192'(busy), 192'(1));
                chk("t6_grant_hold", 192'(grant_idx), 192'(1));
                chk("t6_valid_follows", 192'(oreq.valid), 192'(0));
            end
            tick();
        end
        oresp = '0;
        chk("t6_no_early_grant", 192'(glog.size()), 192'(1));
        tick();
        chk("t6_then_port0", 192'(grant_idx), 192'(0));
        chk("t6_then_busy", 192'(busy), 192'(1));
        run_burst(2, 0);
        tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
